// File: rtl/reservation_station_pkg.sv
// Shared constants and helpers for the reservation station slice.
// Operand/data width, tag width and the READY tag live here so every block agrees on them.
package reservation_station_pkg;

    localparam int WORD_SIZE = 32;
    localparam int FU_INDEX  = 4;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [FU_INDEX-1:0]  tag_t;

    localparam tag_t READY = '0;

    // An operand waiting on a producer captures a broadcast whose tag names that producer.
    function automatic logic operand_hit(input tag_t wait_tag, input logic bus_valid,
                                         input tag_t bus_tag);
        return bus_valid && (wait_tag != READY) && (wait_tag == bus_tag);
    endfunction

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: among ready entries choose the largest age, ties going to the lowest index.
// Purely combinational; produces a one-hot grant, the matching index and an any-ready flag.
module rs_select #(
    parameter int DEPTH = 4,
    parameter int AGE_W = 3,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][AGE_W-1:0] ages,
    output logic [DEPTH-1:0]            grant,
    output logic [IDX_W-1:0]            idx,
    output logic                        any
);

    logic [AGE_W-1:0] best_age;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        best_age = '0;
        // Strict greater-than keeps the earlier (lower) index on equal ages.
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!any || ages[i] > best_age)) begin
                any      = 1'b1;
                idx      = IDX_W'(i);
                best_age = ages[i];
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station for one functional unit: issue with CDB bypass, CDB wakeup,
// oldest-ready dispatch with a stable payload while the FU stalls.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int OP_WIDTH    = 4,
    parameter int RS_DEPTH    = 4,
    parameter int RS_TAG_BASE = 1,
    parameter int AGE_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [OP_WIDTH-1:0]  issue_op,
    input  logic [WORD_SIZE-1:0] issue_val1,
    input  logic [WORD_SIZE-1:0] issue_val2,
    input  logic [FU_INDEX-1:0]  issue_tag1,
    input  logic [FU_INDEX-1:0]  issue_tag2,
    output logic [FU_INDEX-1:0]  issue_tag,
    input  logic                 cdb_valid,
    input  logic [FU_INDEX-1:0]  cdb_tag,
    input  logic [WORD_SIZE-1:0] cdb_data,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    output logic [OP_WIDTH-1:0]  disp_op,
    output logic [WORD_SIZE-1:0] disp_a,
    output logic [WORD_SIZE-1:0] disp_b,
    output logic [FU_INDEX-1:0]  disp_tag
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]                busy;
    logic [RS_DEPTH-1:0][OP_WIDTH-1:0]  op;
    logic [RS_DEPTH-1:0][WORD_SIZE-1:0] val1, val2;
    logic [RS_DEPTH-1:0][FU_INDEX-1:0]  tag1, tag2;
    logic [RS_DEPTH-1:0][AGE_W-1:0]     age;

    logic [RS_DEPTH-1:0] ready_vec, sel_grant, disp_onehot;
    logic [IDX_W-1:0]    sel_idx, free_idx, held_idx, disp_idx;
    logic                sel_any, free_any, held_valid;
    logic                issue_fire, disp_fire, bypass1, bypass2;

    function automatic logic [FU_INDEX-1:0] tag_of(input logic [IDX_W-1:0] i);
        return FU_INDEX'(RS_TAG_BASE + int'(i));
    endfunction

    // Lowest-index free slot; scanning downward lets the last hit win.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++)
            ready_vec[i] = busy[i] && (tag1[i] == READY) && (tag2[i] == READY);
    end

    rs_select #(
        .DEPTH (RS_DEPTH),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (ready_vec),
        .ages  (age),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // A stalled dispatch stays pinned to its entry so an entry woken later cannot displace it.
    always_comb begin
        disp_onehot = sel_grant;
        disp_idx    = sel_idx;
        if (held_valid) begin
            disp_onehot           = '0;
            disp_onehot[held_idx] = 1'b1;
            disp_idx              = held_idx;
        end
    end

    assign disp_valid  = held_valid || sel_any;
    assign disp_fire   = disp_valid && disp_ready;
    assign issue_ready = free_any;
    assign issue_tag   = tag_of(free_idx);
    assign issue_fire  = issue_valid && issue_ready;
    assign bypass1     = operand_hit(issue_tag1, cdb_valid, cdb_tag);
    assign bypass2     = operand_hit(issue_tag2, cdb_valid, cdb_tag);

    always_comb begin
        disp_op  = '0;
        disp_a   = '0;
        disp_b   = '0;
        disp_tag = disp_valid ? tag_of(disp_idx) : '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (disp_onehot[i]) begin
                disp_op = disp_op | op[i];
                disp_a  = disp_a  | val1[i];
                disp_b  = disp_b  | val2[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every entry updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            tag1       <= '0;
            tag2       <= '0;
            age        <= '0;
            held_valid <= 1'b0;
            held_idx   <= '0;
        end else begin
            held_valid <= disp_valid && !disp_ready;
            held_idx   <= disp_idx;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (disp_fire && disp_onehot[i]) begin
                    busy[i] <= 1'b0;
                end else if (issue_fire && free_idx == IDX_W'(i)) begin
                    busy[i] <= 1'b1;
                    tag1[i] <= bypass1 ? READY : issue_tag1;
                    tag2[i] <= bypass2 ? READY : issue_tag2;
                    age[i]  <= '0;
                end else if (busy[i]) begin
                    if (age[i] != '1) age[i] <= age[i] + 1'b1;
                    if (operand_hit(tag1[i], cdb_valid, cdb_tag)) tag1[i] <= READY;
                    if (operand_hit(tag2[i], cdb_valid, cdb_tag)) tag2[i] <= READY;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; it is only observed through busy entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (issue_fire && free_idx == IDX_W'(i)) begin
                op[i]   <= issue_op;
                val1[i] <= bypass1 ? cdb_data : issue_val1;
                val2[i] <= bypass2 ? cdb_data : issue_val2;
            end else if (busy[i]) begin
                if (operand_hit(tag1[i], cdb_valid, cdb_tag)) val1[i] <= cdb_data;
                if (operand_hit(tag2[i], cdb_valid, cdb_tag)) val2[i] <= cdb_data;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: stimulus pushes expected dispatches into a scoreboard,
// a negedge monitor pops and compares each accepted dispatch.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0, issue_ready;
    logic [3:0]  issue_op = '0;
    logic [31:0] issue_val1 = '0, issue_val2 = '0;
    logic [3:0]  issue_tag1 = '0, issue_tag2 = '0, issue_tag;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        disp_valid, disp_ready = 1'b1;
    logic [3:0]  disp_op, disp_tag;
    logic [31:0] disp_a, disp_b;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } disp_t;

    disp_t sb[$];
    int    checks = 0;
    int    errors = 0;

    reservation_station dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_val1  (issue_val1),
        .issue_val2  (issue_val2),
        .issue_tag1  (issue_tag1),
        .issue_tag2  (issue_tag2),
        .issue_tag   (issue_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_op     (disp_op),
        .disp_a      (disp_a),
        .disp_b      (disp_b),
        .disp_tag    (disp_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] v1, input logic [3:0] t1,
                         input logic [31:0] v2, input logic [3:0] t2);
        check("issue_ready_before_issue", issue_ready, 1'b1);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_val1  = v1;
        issue_tag1  = t1;
        issue_val2  = v2;
        issue_tag2  = t2;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        disp_t e;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: every accepted dispatch must match the next expected entry.
    initial begin
        disp_t e;
        forever begin
            @(negedge clk);
            if (!reset && disp_valid && disp_ready) begin
                check("sb_has_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("disp_op", disp_op, e.op);
                    check("disp_a", disp_a, e.a);
                    check("disp_b", disp_b, e.b);
                    check("disp_tag", disp_tag, e.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state, then a fully ready op dispatches the next cycle.
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_issue_tag", issue_tag, 4'd1);
        check("rst_disp_a_zero", disp_a, 32'h0);
        push(4'd3, 32'd5, 32'd7, 4'd1);
        issue(4'd3, 32'd5, 4'd0, 32'd7, 4'd0);
        check("t1_disp_valid", disp_valid, 1'b1);
        tick();

        // 2: pending operand, unrelated broadcast, then matching broadcast wakes it.
        check("t2_issue_tag", issue_tag, 4'd1);
        issue(4'd1, 32'hdead, 4'd6, 32'd2, 4'd0);
        check("t2_wait_valid", disp_valid, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h99;
        tick();
        check("t2_other_tag_no_wake", disp_valid, 1'b0);
        cdb_tag = 4'd6; cdb_data = 32'd9;
        check("t2_wake_is_registered", disp_valid, 1'b0);
        push(4'd1, 32'd9, 32'd2, 4'd1);
        tick();
        cdb_valid = 1'b0;
        check("t2_woken_valid", disp_valid, 1'b1);
        tick();

        // 3: issue-time CDB bypass.
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h11;
        push(4'd2, 32'h11, 32'd4, 4'd1);
        issue(4'd2, 32'hbad, 4'd6, 32'd4, 4'd0);
        cdb_valid = 1'b0;
        check("t3_bypass_valid", disp_valid, 1'b1);
        check("t3_bypass_a", disp_a, 32'h11);
        tick();

        // 4: fill, ignore issue when full, free slot visible only after the dispatch edge.
        disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_alloc_tag", issue_tag, 32'(i + 1));
            push(4'(4 + i), 32'(10 + i), 32'(20 + i), 4'(1 + i));
            issue(4'(4 + i), 32'(10 + i), 4'd0, 32'(20 + i), 4'd0);
        end
        check("t4_full_ready", issue_ready, 1'b0);
        check("t4_full_sel", disp_tag, 4'd1);
        issue_valid = 1'b1; issue_op = 4'd15;
        tick();
        issue_valid = 1'b0;
        check("t4_still_full", issue_ready, 1'b0);
        disp_ready = 1'b1;
        check("t4_no_same_cycle_free", issue_ready, 1'b0);
        tick();
        disp_ready = 1'b0;
        check("t4_freed_ready", issue_ready, 1'b1);
        check("t4_freed_tag", issue_tag, 4'd1);
        disp_ready = 1'b1;
        repeat (4) tick();
        check("t4_drained", disp_valid, 1'b0);

        // 5: oldest first; stall holds A even after an older entry wakes.
        disp_ready = 1'b0;
        issue(4'd10, 32'h0, 4'd5, 32'h55, 4'd0);
        issue(4'd8, 32'h100, 4'd0, 32'h200, 4'd0);
        tick();
        issue(4'd9, 32'h300, 4'd0, 32'h400, 4'd0);
        check("t5_sel_tag", disp_tag, 4'd2);
        check("t5_sel_a", disp_a, 32'h100);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h77;
        tick();
        cdb_valid = 1'b0;
        check("t5_hold_tag", disp_tag, 4'd2);
        check("t5_hold_op", disp_op, 4'd8);
        tick();
        check("t5_hold_b", disp_b, 32'h200);
        push(4'd8, 32'h100, 32'h200, 4'd2);
        push(4'd10, 32'h77, 32'h55, 4'd1);
        push(4'd9, 32'h300, 32'h400, 4'd3);
        disp_ready = 1'b1;
        repeat (4) tick();
        check("t5_drained", disp_valid, 1'b0);

        // 6: asynchronous reset while entries wait on a broadcast.
        disp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(4'd1, 32'(i), 4'd7, 32'(i), 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h42;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_disp_valid", disp_valid, 1'b0);
        check("t6_rst_issue_ready", issue_ready, 1'b1);
        check("t6_rst_issue_tag", issue_tag, 4'd1);
        cdb_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("t6_entries_gone", disp_valid, 1'b0);
        disp_ready = 1'b1;
        repeat (2) tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
